// File: rtl/axi_lite_rr_arbiter.sv
// Two-master / one-slave AXI4-Lite arbiter. It grants the bus for a whole transaction, alternates
// masters round-robin on ties, and fabricates DECERR when the slave stops responding.
module axi_lite_rr_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    output logic [1:0]        m1_bresp,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    output logic              s_wvalid,
    input  logic              s_wready,
    input  logic [1:0]        s_bresp,
    input  logic              s_bvalid,
    output logic              s_bready,
    output logic [1:0]        grant,
    output logic              busy
);
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

    typedef enum logic [2:0] {IDLE, RD, WR, DRAIN_R, DRAIN_B} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;          // 0 = m0, 1 = m1
    logic            last_owner_q, last_owner_d;
    logic            ar_done_q, ar_done_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            to_q, to_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic              waiting, slave_resp, wd_hit, fab, pick1;
    logic              own_arvalid, own_rready, rv;
    logic [ADDR_W-1:0] own_araddr;
    logic [DATA_W-1:0] rdata_o;
    logic [1:0]        resp_o;

    assign waiting     = (state_q == RD && ar_done_q) || (state_q == WR && aw_done_q && w_done_q);
    assign slave_resp  = (state_q == RD) ? s_rvalid : s_bvalid;
    assign wd_hit      = (TIMEOUT != 0) && waiting && (wd_q == WD_MAX);
    // A real response landing in the expiry cycle wins over the fabricated one.
    assign fab         = waiting && (to_q || (wd_hit && !slave_resp));
    assign pick1       = (m1_arvalid || m1_awvalid) && (!m0_arvalid || !last_owner_q);
    assign own_arvalid = owner_q ? m1_arvalid : m0_arvalid;
    assign own_araddr  = owner_q ? m1_araddr : m0_araddr;
    assign own_rready  = owner_q ? m1_rready : m0_rready;
    assign grant       = (state_q == RD || state_q == WR) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        ar_done_d    = ar_done_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        to_d         = to_q || fab;
        wd_d         = wd_q;
        rv           = 1'b0;
        rdata_o      = '0;
        resp_o       = 2'b00;
        m0_arready = 1'b0; m0_rdata = '0; m0_rresp = 2'b00; m0_rvalid = 1'b0;
        m1_arready = 1'b0; m1_rdata = '0; m1_rresp = 2'b00; m1_rvalid = 1'b0;
        m1_awready = 1'b0; m1_wready = 1'b0; m1_bresp = 2'b00; m1_bvalid = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_arvalid || m1_arvalid || m1_awvalid) begin
                    owner_d = pick1;
                    state_d = (pick1 && !m1_arvalid) ? WR : RD;
                end
            end
            RD: begin
                s_arvalid = own_arvalid && !ar_done_q;
                s_araddr  = (own_arvalid && !ar_done_q) ? own_araddr : '0;
                rv        = fab || s_rvalid;
                rdata_o   = (rv && !fab) ? s_rdata : '0;
                resp_o    = fab ? 2'b11 : (rv ? s_rresp : 2'b00);
                s_rready  = own_rready && !fab;
                if (owner_q) begin
                    m1_arready = s_arready && !ar_done_q;
                    m1_rvalid  = rv;
                    m1_rdata   = rdata_o;
                    m1_rresp   = resp_o;
                end else begin
                    m0_arready = s_arready && !ar_done_q;
                    m0_rvalid  = rv;
                    m0_rdata   = rdata_o;
                    m0_rresp   = resp_o;
                end
                if (own_arvalid && !ar_done_q && s_arready) begin
                    ar_done_d = 1'b1;
                    wd_d      = WD_ONE;
                end else if (ar_done_q && wd_q != WD_MAX) begin
                    wd_d = wd_q + WD_ONE;
                end
                if (rv && own_rready) begin
                    state_d      = fab ? DRAIN_R : IDLE;
                    last_owner_d = owner_q;
                    ar_done_d    = 1'b0;
                    wd_d         = '0;
                    to_d         = 1'b0;
                end
            end
            WR: begin
                s_awvalid  = m1_awvalid && !aw_done_q;
                s_awaddr   = (m1_awvalid && !aw_done_q) ? m1_awaddr : '0;
                m1_awready = s_awready && !aw_done_q;
                s_wvalid   = m1_wvalid && !w_done_q;
                s_wdata    = (m1_wvalid && !w_done_q) ? m1_wdata : '0;
                s_wstrb    = (m1_wvalid && !w_done_q) ? m1_wstrb : '0;
                m1_wready  = s_wready && !w_done_q;
                if (m1_awvalid && !aw_done_q && s_awready) begin
                    aw_done_d = 1'b1;
                    wd_d      = WD_ONE;
                end else if (aw_done_q && wd_q != WD_MAX) begin
                    wd_d = wd_q + WD_ONE;
                end
                if (m1_wvalid && !w_done_q && s_wready) w_done_d = 1'b1;
                rv        = fab || (aw_done_q && w_done_q && s_bvalid);
                m1_bvalid = rv;
                m1_bresp  = fab ? 2'b11 : (rv ? s_bresp : 2'b00);
                s_bready  = aw_done_q && w_done_q && m1_bready && !fab;
                if (rv && m1_bready) begin
                    state_d      = fab ? DRAIN_B : IDLE;
                    last_owner_d = 1'b1;
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    wd_d         = '0;
                    to_d         = 1'b0;
                end
            end
            DRAIN_R: begin
                s_rready = 1'b1;
                if (s_rvalid) state_d = IDLE;
            end
            DRAIN_B: begin
                s_bready = 1'b1;
                if (s_bvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            ar_done_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            to_q         <= 1'b0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            ar_done_q    <= ar_done_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            to_q         <= to_d;
            wd_q         <= wd_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Scoreboard bench for axi_lite_rr_arbiter with a small AXI-Lite slave model and TIMEOUT=8.
module tb_axi_lite_rr_arbiter;
    typedef logic [33:0] exp_t;   // {rdata, rresp}

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata, s_araddr, s_awaddr, s_wdata;
    logic [31:0] m0_rdata, m1_rdata, s_rdata;
    logic [7:0]  m1_wstrb, s_wstrb;
    logic [1:0]  m0_rresp, m1_rresp, m1_bresp, s_rresp, s_bresp, grant;
    logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
    logic s_wvalid, s_wready, s_bvalid, s_bready, busy;

    axi_lite_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .STRB_W(8), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant(grant), .busy(busy)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t       q0[$], q1r[$];
    logic [1:0] q1b[$];
    int         order_log[$];
    logic [1:0] grant_log[$];
    int         grant_cyc_log[$];
    int         r_hs_q[$];
    int         m0_rv_rise = 0;

    // slave model controls and observations
    int          rd_lat = 3;
    logic        rd_hang = 1'b0;
    logic        aw_hold = 1'b0;
    int          ar_cyc = 0, aw_cyc = 0, w_cyc = 0, aw_rise_cyc = 0, r_hs_cyc = 0;
    int          aw_cnt = 0, w_cnt = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0;
    logic [7:0]  cap_wstrb = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return {a[15:0], a[31:16]} ^ 32'h0F0F_0F0F;
    endfunction

    // slave: samples handshakes at negedge, updates drives just after posedge
    initial begin
        logic ar_p, aw_s, w_s, aw_prev;
        logic [31:0] ra;
        ar_p = 0; aw_s = 0; w_s = 0; aw_prev = 0; ra = '0;
        s_arready = 1; s_rvalid = 0; s_rdata = '0; s_rresp = 2'b00;
        s_awready = 1; s_wready = 1; s_bvalid = 0; s_bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ar_p = 0; aw_s = 0; w_s = 0;
            end else begin
                if (s_rvalid && s_rready) begin ar_p = 0; r_hs_cyc = cyc; r_hs_q.push_back(cyc); end
                if (s_arvalid && s_arready) begin ar_p = 1; ra = s_araddr; ar_cyc = cyc; end
                if (s_awvalid && !aw_prev) aw_rise_cyc = cyc;
                if (s_awvalid && s_awready) begin
                    aw_s = 1; aw_cnt++; aw_cyc = cyc; cap_awaddr = s_awaddr;
                end
                if (s_wvalid && s_wready) begin
                    w_s = 1; w_cnt++; w_cyc = cyc; cap_wdata = s_wdata; cap_wstrb = s_wstrb;
                end
                if (s_bvalid && s_bready) begin aw_s = 0; w_s = 0; end
            end
            aw_prev = s_awvalid;
            @(posedge clk); #1;
            s_rvalid  = ar_p && !rd_hang && (cyc >= ar_cyc + rd_lat);
            s_rdata   = s_rvalid ? rd_fn(ra) : '0;
            s_awready = !aw_hold || (w_s && cyc >= w_cyc + 2);
            s_bvalid  = aw_s && w_s;
        end
    end

    // scoreboard / monitor
    initial begin
        exp_t e;
        logic [1:0] grant_prev;
        logic m0_rv_prev;
        grant_prev = 2'b00; m0_rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (m0_rvalid && m0_rready) begin
                    if (q0.size() == 0) chk("m0_r_unexpected", 1, 0);
                    else begin
                        e = q0.pop_front();
                        chk("m0_rdata", m0_rdata, e[33:2]);
                        chk("m0_rresp", m0_rresp, e[1:0]);
                    end
                    order_log.push_back(0);
                end
                if (m1_rvalid && m1_rready) begin
                    if (q1r.size() == 0) chk("m1_r_unexpected", 1, 0);
                    else begin
                        e = q1r.pop_front();
                        chk("m1_rdata", m1_rdata, e[33:2]);
                        chk("m1_rresp", m1_rresp, e[1:0]);
                    end
                    order_log.push_back(1);
                end
                if (m1_bvalid && m1_bready) begin
                    if (q1b.size() == 0) chk("m1_b_unexpected", 1, 0);
                    else chk("m1_bresp", m1_bresp, q1b.pop_front());
                    order_log.push_back(2);
                end
                if (!m0_rvalid) chk("m0_rdata_idle", m0_rdata, 0);
                if (grant != 2'b10) chk("m1_awready_held", m1_awready, 0);
                if (grant != 2'b00 && grant != grant_prev) begin
                    grant_log.push_back(grant);
                    grant_cyc_log.push_back(cyc);
                end
                if (m0_rvalid && !m0_rv_prev) m0_rv_rise = cyc;
            end
            grant_prev = grant;
            m0_rv_prev = m0_rvalid;
        end
    end

    task automatic m0_rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n;
        q0.push_back({ed, er});
        @(posedge clk); #1;
        m0_araddr = a; m0_arvalid = 1; m0_rready = 1;
        n = 0;
        @(negedge clk);
        while (!m0_arready && n < 200) begin n++; @(negedge clk); end
        chk("m0_ar_wait", n < 200, 1);
        @(posedge clk); #1;
        m0_arvalid = 0; m0_araddr = '0;
        n = 0;
        @(negedge clk);
        while (!m0_rvalid && n < 200) begin n++; @(negedge clk); end
        chk("m0_r_wait", n < 200, 1);
        @(posedge clk); #1;
        m0_rready = 0;
    endtask

    task automatic m1_rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n;
        q1r.push_back({ed, er});
        @(posedge clk); #1;
        m1_araddr = a; m1_arvalid = 1; m1_rready = 1;
        n = 0;
        @(negedge clk);
        while (!m1_arready && n < 200) begin n++; @(negedge clk); end
        chk("m1_ar_wait", n < 200, 1);
        @(posedge clk); #1;
        m1_arvalid = 0; m1_araddr = '0;
        n = 0;
        @(negedge clk);
        while (!m1_rvalid && n < 200) begin n++; @(negedge clk); end
        chk("m1_r_wait", n < 200, 1);
        @(posedge clk); #1;
        m1_rready = 0;
    endtask

    task automatic m1_wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
        int n;
        logic ad, wd, ah, wh;
        q1b.push_back(2'b00);
        @(posedge clk); #1;
        m1_awaddr = a; m1_awvalid = 1; m1_wdata = d; m1_wstrb = s; m1_wvalid = 1; m1_bready = 1;
        n = 0; ad = 0; wd = 0;
        while (!(ad && wd) && n < 200) begin
            @(negedge clk);
            ah = m1_awvalid && m1_awready;
            wh = m1_wvalid && m1_wready;
            @(posedge clk); #1;
            if (ah) begin m1_awvalid = 0; m1_awaddr = '0; ad = 1; end
            if (wh) begin m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; wd = 1; end
            n++;
        end
        chk("m1_aw_w_wait", ad && wd, 1);
        n = 0;
        @(negedge clk);
        while (!m1_bvalid && n < 200) begin n++; @(negedge clk); end
        chk("m1_b_wait", n < 200, 1);
        @(posedge clk); #1;
        m1_bready = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n, b0, b1;
        m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
        m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
        m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;

        // reset state
        @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_awvalid", s_awvalid, 0);
        chk("rst_s_rready", s_rready, 0);

        // single m0 read, one cycle of arbitration latency
        fork
            m0_rd(32'h8000_0000, 32'h0000_0413, 2'b00);
            begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("t1_grant_latency", grant, 2'b00);
                @(negedge clk);
                chk("t1_grant", grant, 2'b01);
                chk("t1_busy", busy, 1);
            end
        join
        @(negedge clk);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_grant", grant, 2'b00);

        // tie after m0 was last owner -> m1 first
        order_log.delete(); grant_log.delete();
        fork
            m0_rd(32'h8000_0100, rd_fn(32'h8000_0100), 2'b00);
            m1_rd(32'h8000_0200, rd_fn(32'h8000_0200), 2'b00);
        join
        chk("tieA_n", order_log.size(), 2);
        if (order_log.size() == 2) begin
            chk("tieA_first", order_log[0], 1);
            chk("tieA_second", order_log[1], 0);
        end

        // tie right after reset -> m0, then m1; a repeated tie goes to m0 again
        do_reset();
        order_log.delete(); grant_log.delete();
        fork
            m0_rd(32'h8000_0300, rd_fn(32'h8000_0300), 2'b00);
            m1_rd(32'h8000_0400, rd_fn(32'h8000_0400), 2'b00);
        join
        fork
            m0_rd(32'h8000_0500, rd_fn(32'h8000_0500), 2'b00);
            m1_rd(32'h8000_0600, rd_fn(32'h8000_0600), 2'b00);
        join
        chk("tieB_n", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            chk("tieB_g0", grant_log[0], 2'b01);
            chk("tieB_g1", grant_log[1], 2'b10);
            chk("tieC_g2", grant_log[2], 2'b01);
            chk("tieC_g3", grant_log[3], 2'b10);
        end

        // write with W accepted two cycles before AW
        b0 = aw_cnt; b1 = w_cnt;
        aw_hold = 1;
        m1_wr(32'h8000_1000, 32'hDEAD_BEEF, 8'h0F);
        aw_hold = 0;
        chk("wr_aw_count", aw_cnt - b0, 1);
        chk("wr_w_count", w_cnt - b1, 1);
        chk("wr_w_before_aw", aw_cyc - w_cyc, 2);
        chk("wr_awaddr", cap_awaddr, 32'h8000_1000);
        chk("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", cap_wstrb, 8'h0F);

        // m1 read and write together -> read first
        order_log.delete();
        fork
            m1_rd(32'h8000_0700, rd_fn(32'h8000_0700), 2'b00);
            m1_wr(32'h8000_2000, 32'h1111_2222, 8'hF0);
        join
        chk("rw_read_before_aw", r_hs_cyc < aw_rise_cyc, 1);
        chk("rw_n", order_log.size(), 2);
        if (order_log.size() == 2) chk("rw_first", order_log[0], 1);

        // watchdog: slave never answers, DECERR on cycle 8, late response drained
        rd_hang = 1;
        m0_rd(32'h8000_3000, 32'h0, 2'b11);
        chk("wd_cycle", m0_rv_rise - ar_cyc, 8);
        r_hs_q.delete(); grant_log.delete(); grant_cyc_log.delete();
        fork
            m1_rd(32'h8000_3100, rd_fn(32'h8000_3100), 2'b00);
            begin
                repeat (4) @(negedge clk);
                chk("drain_busy", busy, 1);
                chk("drain_grant", grant, 2'b00);
                chk("drain_s_rready", s_rready, 1);
                @(posedge clk); #1;
                rd_hang = 0;
            end
        join
        chk("drain_hs_n", r_hs_q.size(), 2);
        chk("drain_grant_n", grant_cyc_log.size(), 1);
        if (r_hs_q.size() >= 1 && grant_cyc_log.size() >= 1) begin
            chk("drain_grant_after", grant_cyc_log[0] > r_hs_q[0], 1);
            chk("drain_grant_val", grant_log[0], 2'b10);
        end

        // reset in WR after the AW handshake
        @(posedge clk); #1;
        m1_awaddr = 32'h8000_4000; m1_awvalid = 1;
        n = 0;
        @(negedge clk);
        while (!m1_awready && n < 200) begin n++; @(negedge clk); end
        chk("rst_aw_wait", n < 200, 1);
        @(posedge clk); #1;
        m1_awvalid = 0; m1_awaddr = '0; rst = 0;
        @(negedge clk);
        chk("rstwr_pre_grant", grant, 2'b10);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("rstwr_grant", grant, 2'b00);
        chk("rstwr_busy", busy, 0);
        chk("rstwr_valids", {s_arvalid, s_awvalid, s_wvalid, m0_rvalid, m1_rvalid, m1_bvalid}, 6'b0);
        chk("rstwr_readys", {m0_arready, m1_arready, m1_awready, m1_wready, s_rready, s_bready}, 6'b0);
        b0 = aw_cnt;
        m1_wr(32'h8000_5000, 32'h1234_5678, 8'hFF);
        chk("rstwr_aw_after", aw_cnt - b0, 1);
        chk("rstwr_awaddr", cap_awaddr, 32'h8000_5000);

        repeat (3) @(negedge clk);
        chk("q0_empty", q0.size(), 0);
        chk("q1r_empty", q1r.size(), 0);
        chk("q1b_empty", q1b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_lite_rr_arbiter.md
Name: axi_lite_rr_arbiter

Overview:
- Two-master, one-slave AXI4-Lite arbiter. It shares the single memory/device port between the fetch unit (m0, read-only) and the load/store path (m1, read and write).
- The bus is granted for one whole transaction at a time. Masters alternate round-robin when both request.
- A response watchdog lets a hung slave return an error to the core instead of deadlocking the multicycle pipeline.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STRB_W, 8, write-strobe width (matches existing LSU wstrb)
TIMEOUT, 255, cycles from slave address handshake to response before an error is fabricated; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
m0_ar  araddr in ADDR_W, arvalid in 1, arready out 1  fetch read address
m0_r   rdata out DATA_W, rresp out 2, rvalid out 1, rready in 1  fetch read data
m1_ar  araddr in ADDR_W, arvalid in 1, arready out 1  LSU read address
m1_r   rdata out DATA_W, rresp out 2, rvalid out 1, rready in 1  LSU read data
m1_aw  awaddr in ADDR_W, awvalid in 1, awready out 1  LSU write address
m1_w   wdata in DATA_W, wstrb in STRB_W, wvalid in 1, wready out 1  LSU write data
m1_b   bresp out 2, bvalid out 1, bready in 1  LSU write response
s_ar   araddr out ADDR_W, arvalid out 1, arready in 1  slave read address
s_r    rdata in DATA_W, rresp in 2, rvalid in 1, rready out 1  slave read data
s_aw   awaddr out ADDR_W, awvalid out 1, awready in 1  slave write address
s_w    wdata out DATA_W, wstrb out STRB_W, wvalid out 1, wready in 1  slave write data
s_b    bresp in 2, bvalid in 1, bready out 1  slave write response
grant  out 2  one-hot owner; 00 when idle
busy   out 1  high in any state other than IDLE

Behaviour:
- States: IDLE, RD, WR, DRAIN_R, DRAIN_B. Reset (rst=0 at posedge) forces IDLE, last_owner=m1 (m0 wins the first tie), aw_done=w_done=0, watchdog=0.
- Outputs in IDLE and DRAIN_*: all valid/ready signals to masters are 0, and s_*valid are 0. Data/resp outputs are 0 whenever the matching valid is 0.
- Arbitration (IDLE only) uses the request set {m0_arvalid, m1_arvalid|m1_awvalid}:
  - Single requester wins.
  - On a tie, the master other than last_owner wins.
  - Inside m1, a read takes priority over a write.
  - The next state (RD or WR) is registered. grant and the combinational channel muxing start the following cycle, so there is exactly 1 cycle of arbitration latency.
- RD: owner's AR and R channels are wired straight through to s_ar/s_r.
  - Leave on the R handshake (rvalid&rready at the owner), returning to IDLE next cycle.
  - last_owner is updated on exit.
- WR (m1 only): AW and W are forwarded independently.
  - aw_done/w_done are set on their handshakes. Once a channel is done, its slave valid and master ready are masked to 0.
  - B is forwarded only after both are done. The B handshake leads to IDLE and clears both flags.
- Watchdog: counts cycles while waiting for R or B after the address handshake.
  - When the count reaches TIMEOUT, the owner receives a 1-cycle-or-more rvalid/bvalid with resp=2'b11 (DECERR) and rdata=0, held until the owner's ready.
  - The state then moves to DRAIN_R/DRAIN_B. The drain state asserts s_rready/s_bready=1 and discards the first slave response, then goes to IDLE. Masters are not granted during drain.
- Simultaneous events: a response arriving in the same cycle the counter hits TIMEOUT is treated as a normal response; the real response wins.
- Reset mid-transaction: abandons it immediately; all outputs take their reset values the next cycle.
- Master valids are never dropped by the arbiter. A master held off in IDLE sees ready=0 until granted.
- Width rules: the watchdog is clog2(TIMEOUT+1) bits and saturating. Resp and data pass through unmodified.

Test Plan:
- m0 arvalid alone, addr 0x8000_0000; slave returns rdata 0x0000_0413 after 3 cycles -> grant=01 one cycle after request, m0 rdata=0x0000_0413 rresp=00, then IDLE.
- m0 and m1 arvalid asserted in the same cycle right after reset -> m0 served first. Then m1 (grant 10). Then a repeated tie after m1 completes goes to m0.
- m1 write 0x8000_1000 / data 0xDEADBEEF / wstrb 0x0F with W accepted 2 cycles before AW -> exactly one s_wvalid and one s_awvalid handshake, then m1 bvalid bresp=00.
- m1 arvalid and awvalid asserted together -> read transaction completes before s_awvalid rises.
- TIMEOUT=8, slave never asserts rvalid -> on cycle 8 after AR the master sees rresp=11 rdata=0. A late s_rvalid is swallowed with s_rready=1, and the next request is granted only after it.
- rst=0 asserted during WR after the AW handshake -> next cycle grant=00, busy=0, and all valids/readys 0.
